// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave/master blocks.
//   i2c_state_e  : slave protocol state
//   I2C_ACK/NACK : SDA level on the ninth clock
//   SYNC_STAGES  : flops in each SCL/SDA input synchroniser
package i2c_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_RX,
    ST_DEV_ACK,
    ST_WA_RX,
    ST_WA_ACK,
    ST_WR_RX,
    ST_WR_ACK,
    ST_RD_TX,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the asynchronous SCL/SDA pins into the clk domain and
// derives line events. Each event is a single-clk combinational pulse
// off the edge-detect flop, so a registered consumer acts on it 3 clk
// after the pin transition.
//   clk, reset        : system clock, async active-low reset
//   scl_i, sda_i      : raw bus pins
//   sda               : synchronised SDA level (for bit sampling)
//   scl_rise/scl_fall : SCL edges
//   start_det         : SDA fall while SCL high
//   stop_det          : SDA rise while SCL high
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;

  // Bus idles high, so the flops reset high to avoid a false event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign sda       = sda_s;
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SCL must be high on both samples so an SCL edge never masquerades
  // as START/STOP.
  assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// Clocked I2C EEPROM-style slave memory: byte/page writes, current-address,
// random and sequential reads. SDA is open drain (sda_oe=1 pulls low).
//   clk, reset      : system clock (>= 10x SCL), async active-low reset
//   scl_i, sda_i    : bus pins (asynchronous)
//   sda_oe          : pull SDA low
//   busy            : addressed and in a transfer
//   wr_stb/addr/data: one-clk pulse per committed memory write
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'b0101110,
  parameter int         ADDR_W   = 8,
  parameter int         PAGE_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  logic [7:0]        mem [0:DEPTH-1];
  i2c_state_e        state;
  logic [3:0]        cnt;   // bits received, or bits driven in RD_TX
  logic [7:0]        sh;    // receive shift register
  logic [7:0]        tx;    // transmit shift register
  logic [ADDR_W-1:0] ptr;
  logic              rw;
  logic              mack;  // master ACK/NACK sampled in RD_ACK
  logic [7:0]        rd_byte;
  logic [ADDR_W-1:0] ptr_page_inc;

  assign rd_byte      = mem[ptr];
  // Writes wrap inside the current page; the page bits stay put.
  assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + ADDR_W'(1)) & PAGE_MASK);

  // The commit strobe itself performs the write, one clk later; reads
  // only fetch at the next byte boundary so they always see it.
  always_ff @(posedge clk) begin
    if (wr_stb) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= '0;
      cnt     <= '0;
      sh      <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      mack    <= I2C_NACK;
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state  <= ST_DEV_RX;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_DEV_RX, ST_WA_RX, ST_WR_RX: begin
            sh  <= {sh[6:0], sda};
            cnt <= cnt + 4'd1;
          end
          ST_RD_ACK: mack <= sda;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_DEV_RX: if (cnt == 4'd8) begin
            if (sh[7:1] == DEV_ADDR) begin
              state  <= ST_DEV_ACK;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= sh[0];
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_DEV_ACK: begin
            cnt <= '0;
            if (rw) begin
              // Bit 7 goes out on this same fall; cnt tracks bits driven.
              state  <= ST_RD_TX;
              tx     <= rd_byte;
              sda_oe <= ~rd_byte[7];
              cnt    <= 4'd1;
            end else begin
              state  <= ST_WA_RX;
              sda_oe <= 1'b0;
            end
          end
          ST_WA_RX: if (cnt == 4'd8) begin
            ptr    <= sh[ADDR_W-1:0];
            state  <= ST_WA_ACK;
            sda_oe <= 1'b1;
          end
          ST_WA_ACK, ST_WR_ACK: begin
            state  <= ST_WR_RX;
            sda_oe <= 1'b0;
            cnt    <= '0;
          end
          ST_WR_RX: if (cnt == 4'd8) begin
            wr_stb  <= 1'b1;
            wr_addr <= ptr;
            wr_data <= sh;
            ptr     <= ptr_page_inc;
            state   <= ST_WR_ACK;
            sda_oe  <= 1'b1;
          end
          ST_RD_TX: begin
            if (cnt == 4'd8) begin
              state  <= ST_RD_ACK;
              sda_oe <= 1'b0;
              ptr    <= ptr + ADDR_W'(1);
            end else begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
              cnt    <= cnt + 4'd1;
            end
          end
          ST_RD_ACK: begin
            if (mack == I2C_ACK) begin
              state  <= ST_RD_TX;
              tx     <= rd_byte;
              sda_oe <= ~rd_byte[7];
              cnt    <= 4'd1;
            end else begin
              state <= ST_IGNORE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged master, open-drain bus
// model, strobe/sda_oe monitors and hand-computed expectations.
module tb_i2c_eeprom_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, wr_stb;
  logic [7:0] wr_addr, wr_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int n_chk = 0;
  int n_fail = 0;

  int         stb_cnt = 0;
  int         stb_long = 0;
  int         oe_cnt = 0;
  logic       stb_prev = 1'b0;
  logic [7:0] last_addr = '0;
  logic [7:0] last_data = '0;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk    (clk),
    .reset  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .busy   (busy),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always @(posedge clk) begin
    if (wr_stb) begin
      stb_cnt   <= stb_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
      if (stb_prev) stb_long <= stb_long + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    stb_prev <= wr_stb;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(10);
    sda_m = 1'b0; tick(10);
    scl = 1'b0;   tick(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(5);
    scl = 1'b1;   tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  tick(5);
    scl = 1'b1; tick(10);
    scl = 1'b0; tick(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(5);
    ack = sda_bus; tick(5);
    scl = 1'b0;   tick(5);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(5);
      scl = 1'b1;   tick(5);
      d[i] = sda_bus; tick(5);
      scl = 1'b0;   tick(5);
    end
    sda_m = ~master_ack; tick(5);
    scl = 1'b1; tick(10);
    scl = 1'b0; tick(5);
  endtask

  // START, write control, word address: both must be ACKed.
  task automatic addr_phase(input logic [7:0] a);
    logic ack;
    i2c_start();
    send_byte(8'h5C, ack); chk("ack_ctrl_w", ack, 1'b0);
    send_byte(a, ack);     chk("ack_waddr", ack, 1'b0);
  endtask

  task automatic rd_at(input logic [7:0] a, output logic [7:0] d);
    logic ack;
    addr_phase(a);
    i2c_start();
    send_byte(8'h5D, ack); chk("ack_ctrl_r", ack, 1'b0);
    recv_byte(d, 1'b0);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         s0, o0;

    tick(5);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    rst_n = 1'b1;
    tick(5);

    // Byte write 10 <= A5
    s0 = stb_cnt;
    addr_phase(8'h10);
    chk("busy_in_write", busy, 1'b1);
    send_byte(8'hA5, ack); chk("ack_data", ack, 1'b0);
    i2c_stop();
    chk("bw_stb_count", stb_cnt - s0, 1);
    chk("bw_wr_addr", last_addr, 8'h10);
    chk("bw_wr_data", last_data, 8'hA5);
    chk("busy_after_stop", busy, 1'b0);

    // Random read of 10 with master NACK, then slave must stay off the bus
    addr_phase(8'h10);
    i2c_start();
    send_byte(8'h5D, ack); chk("rr_ack_ctrl", ack, 1'b0);
    recv_byte(d, 1'b0);
    chk("rr_data", d, 8'hA5);
    chk("rr_busy_after_nack", busy, 1'b0);
    o0 = oe_cnt;
    send_byte(8'h00, ack); chk("rr_ignore_ack", ack, 1'b1);
    i2c_stop();
    chk("rr_oe_after_nack", oe_cnt - o0, 0);

    // Page wrap: 08 <= 77 first, then 06..: 01,02,03 -> 06,07,00
    addr_phase(8'h08);
    send_byte(8'h77, ack); chk("pg_ack_08", ack, 1'b0);
    i2c_stop();
    s0 = stb_cnt;
    addr_phase(8'h06);
    send_byte(8'h01, ack); chk("pg_ack_1", ack, 1'b0);
    send_byte(8'h02, ack); chk("pg_ack_2", ack, 1'b0);
    send_byte(8'h03, ack); chk("pg_ack_3", ack, 1'b0);
    i2c_stop();
    chk("pg_stb_count", stb_cnt - s0, 3);
    chk("pg_last_addr", last_addr, 8'h00);
    chk("pg_last_data", last_data, 8'h03);
    rd_at(8'h06, d); chk("pg_rd_06", d, 8'h01);
    rd_at(8'h07, d); chk("pg_rd_07", d, 8'h02);
    rd_at(8'h00, d); chk("pg_rd_00", d, 8'h03);
    rd_at(8'h08, d); chk("pg_rd_08", d, 8'h77);

    // Wrong device address
    s0 = stb_cnt; o0 = oe_cnt;
    i2c_start();
    send_byte(8'h5E, ack); chk("wa_nack_ctrl", ack, 1'b1);
    send_byte(8'h10, ack); chk("wa_nack_addr", ack, 1'b1);
    send_byte(8'h99, ack); chk("wa_nack_data", ack, 1'b1);
    chk("wa_busy", busy, 1'b0);
    i2c_stop();
    chk("wa_oe_cycles", oe_cnt - o0, 0);
    chk("wa_stb_count", stb_cnt - s0, 0);

    // Sequential read across the top of memory
    addr_phase(8'hFE);
    send_byte(8'hC3, ack); chk("sq_ack_fe", ack, 1'b0);
    send_byte(8'h3C, ack); chk("sq_ack_ff", ack, 1'b0);
    i2c_stop();
    addr_phase(8'hFE);
    i2c_start();
    send_byte(8'h5D, ack); chk("sq_ack_ctrl", ack, 1'b0);
    recv_byte(d, 1'b1); chk("sq_rd_fe", d, 8'hC3);
    recv_byte(d, 1'b1); chk("sq_rd_ff", d, 8'h3C);
    recv_byte(d, 1'b0); chk("sq_rd_00", d, 8'h03);
    i2c_stop();

    // Partial data byte then STOP: nothing committed
    s0 = stb_cnt;
    addr_phase(8'h30);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    chk("partial_stb", stb_cnt - s0, 0);

    // Reset while the slave drives read data (mem[06]=01, bit 7 = 0)
    addr_phase(8'h06);
    i2c_start();
    send_byte(8'h5D, ack); chk("rs_ack_ctrl", ack, 1'b0);
    chk("rs_oe_before", sda_oe, 1'b1);
    chk("rs_busy_before", busy, 1'b1);
    rst_n = 1'b0; #1;
    chk("rs_oe_async", sda_oe, 1'b0);
    chk("rs_busy_async", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(10);
    s0 = stb_cnt;
    addr_phase(8'h20);
    send_byte(8'h5A, ack); chk("rs_ack_data", ack, 1'b0);
    i2c_stop();
    chk("rs_stb_count", stb_cnt - s0, 1);
    chk("rs_wr_addr", last_addr, 8'h20);
    rd_at(8'h20, d); chk("rs_rd_20", d, 8'h5A);

    chk("stb_width", stb_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Synthesisable, clocked I2C slave memory: a parametrised successor to the behavioural EEPROM model. It oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, and supports byte/page writes, current-address reads, random reads and sequential reads. It sits on the board-level I2C bus as the target device for the team's I2C master and bench stimulus.

## Interface
Parameters:
- DEV_ADDR, 7'b0101110, 7-bit slave address; write control byte is {DEV_ADDR,0} = 8'h5C
- ADDR_W, 8, word-address width (1..8); DEPTH = 2**ADDR_W bytes
- PAGE_W, 3, page size = 2**PAGE_W bytes (PAGE_W ≤ ADDR_W)

Ports:
- clk  in  1  system clock; frequency ≥ 10× SCL
- reset  in  1  asynchronous, active-low reset
- scl_i  in  1  bus SCL, asynchronous
- sda_i  in  1  bus SDA, asynchronous
- sda_oe  out  1  1 = pull SDA low; 0 = release (open drain, never drives 1)
- busy  out  1  high from matching address ACK until STOP/START/NACK-exit
- wr_stb  out  1  one-clk pulse per committed memory write
- wr_addr  out  ADDR_W  address of committed write
- wr_data  out  8  data of committed write

## Operation
- Reset: state IDLE, sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, ptr=0; memory contents not reset.
- Line events from synchronised signals: START = SDA fall while SCL high; STOP = SDA rise while SCL high; bits sampled on SCL rise; sda_oe changes only on SCL fall.
- START from any state (incl. mid-byte, mid-ACK) → DEV_RX, bit counter cleared, sda_oe=0. STOP from any state → IDLE, sda_oe=0, busy=0.
- States: IDLE → DEV_RX (8 bits, MSB first) → DEV_ACK → {WA_RX | RD_TX}; WA_RX → WA_ACK → WR_RX; WR_RX → WR_ACK → WR_RX; RD_TX → RD_ACK → RD_TX (master ACK) or IGNORE (master NACK).
- DEV_RX address mismatch: do not ACK (sda_oe stays 0), go IGNORE until next START/STOP.
- Match with R/W=0: ACK, receive word address; ptr = low ADDR_W bits of byte (upper bits ignored); ACK.
- WR_RX: each full byte written to mem[ptr] during ACK; wr_stb/wr_addr/wr_data pulse on the SCL fall that begins the ACK; ptr low PAGE_W bits increment with wrap inside the page, upper bits fixed.
- Match with R/W=1: ACK, then shift out mem[ptr] MSB first (bit 0 → sda_oe=1). After 8 bits release SDA, sample master ACK on SCL rise; ptr increments mod DEPTH after each byte.
- Random read: write control, word address, repeated START, read control → data from new ptr.
- Write followed by STOP before 8 bits: partial byte discarded, no wr_stb.

## Timing
- Input synchroniser 2 flops + 1 edge-detect flop: line events acted on 3 clk after the pin transition.
- ACK: sda_oe=1 asserted 3 clk after SCL fall ending bit 8; released 3 clk after the next SCL fall.
- Read data bit valid 3 clk after SCL fall; master must hold SCL low ≥ 4 clk (guaranteed by clk ≥ 10× SCL).
- wr_stb high exactly 1 clk; memory readable via read transaction from the next byte onward.
- Reset asserted mid-transaction: outputs to reset values immediately (async); bus released.

## Structure
- Package i2c_pkg: state enum, I2C_ACK/I2C_NACK constants, synchroniser depth constant.
- Sub-module i2c_line_sync: 2-flop synchronisers for SCL/SDA, outputs scl_rise, scl_fall, start_det, stop_det (reused by the master).
- Memory as inferred array reg [7:0] mem [0:DEPTH-1].

## Test plan
- Byte write: START, 8'h5C, 8'h10, 8'hA5, STOP → three ACKs, wr_stb once with wr_addr=8'h10, wr_data=8'hA5.
- Random read: write 8'h10, repeated START, 8'h5D → ACK, data 8'hA5, master NACK → sda_oe=0 until STOP.
- Page wrap: write at 8'h06 of bytes 1,2,3 → stored at 8'h06, 8'h07, 8'h00; 8'h08 unchanged.
- Wrong address 8'h5E → no ACK, sda_oe=0 for whole transaction, no wr_stb.
- Sequential read from 8'hFE, 3 bytes with master ACKs → mem[FE], mem[FF], mem[00].
- Reset pulse during data byte → sda_oe=0, busy=0 at once; next full transaction to 8'h20 succeeds.
